// File: rtl/stim_pkg.sv
// Shared definitions for the stimulus player.
//   state_t  : playback FSM states (binary encoded)
//   OP_W     : width of one stored opcode vector
//   OP_LINE1 / OP_LINE2 / OP_OBS : bit positions inside an opcode
package stim_pkg;

  localparam int OP_W     = 3;
  localparam int OP_LINE1 = 0;
  localparam int OP_LINE2 = 1;
  localparam int OP_OBS   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/stim_ram.sv
// Opcode store: DEPTH x OP_W, synchronous write, asynchronous read.
// The array has no reset; contents are undefined until loaded.
// Ports:
//   i_clk      : clock
//   i_wr_en    : write strobe (already qualified by the caller)
//   i_wr_addr  : write address
//   i_wr_data  : opcode to store
//   i_rd_addr  : read address
//   o_rd_data  : combinational read data
module stim_ram
  import stim_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_wr_en,
  input  logic [AW-1:0]   i_wr_addr,
  input  logic [OP_W-1:0] i_wr_data,
  input  logic [AW-1:0]   i_rd_addr,
  output logic [OP_W-1:0] o_rd_data
);

  logic [OP_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/stim_player.sv
// Stimulus player: replays len stored opcode vectors onto line1/line2/obs,
// one per clock, then pulses done for one cycle.
// Ports:
//   clock, reset        : clock; asynchronous active-low reset
//   wr_en/wr_addr/wr_data : opcode store write port (ignored while running)
//   start, len          : launch a run of len vectors (sampled in IDLE)
//   stop                : abort a running playback, no done pulse
//   line1, line2, obs   : registered opcode bits of the current vector
//   vec_valid           : a stored vector is on line1/line2/obs
//   pc                  : index of the vector on the outputs (zero-extended)
//   busy                : FSM in RUN
//   done                : one-cycle completion pulse (FSM in DONE)
//   dbg_state           : FSM state, for observation only
//
// Handshake: start is a level sampled only in IDLE; there is no ready/ack,
// starts seen in RUN or DONE are dropped. Vector k of a run started at edge
// N is on the outputs after edge N+1+k; the cycle after the final vector is
// the single DONE cycle.
module stim_player
  import stim_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [2:0]    wr_data,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic          stop,
  output logic          line1,
  output logic          line2,
  output logic          obs,
  output logic          vec_valid,
  output logic [31:0]   pc,
  output logic          busy,
  output logic          done,
  output logic [1:0]    dbg_state
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  // Reset asserts asynchronously and releases on a clock edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_addr;
  logic [AW-1:0]   r_last;
  logic            r_fin;
  logic [OP_W-1:0] r_op;
  logic            r_vec_valid;
  logic [AW-1:0]   r_pc;
  logic [OP_W-1:0] w_rd_data;
  logic            w_wr;
  logic [AW-1:0]   w_last;
  logic            w_launch;

  // The store is frozen while a run is in progress.
  assign w_wr = wr_en && (r_state != ST_RUN);

  // Index of the final vector; lengths above DEPTH clamp to DEPTH, and
  // len == DEPTH wraps len-1 to all-ones in AW bits, which is correct.
  assign w_last   = (len > DEPTH_L) ? '1 : (len[AW-1:0] - AW'(1));
  assign w_launch = start && (len != '0);

  stim_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk     (clock),
    .i_wr_en   (w_wr),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_addr (r_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = w_launch ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        // stop wins over the final-vector transition.
        if (stop)       w_next = ST_IDLE;
        else if (r_fin) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // r_fin marks that the final vector is on the outputs; the address stops
  // at r_last rather than incrementing, so it never wraps within a run.
  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_addr      <= '0;
      r_last      <= '0;
      r_fin       <= 1'b0;
      r_op        <= '0;
      r_vec_valid <= 1'b0;
      r_pc        <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (stop || r_fin) begin
            r_op        <= '0;
            r_vec_valid <= 1'b0;
          end else begin
            r_op        <= w_rd_data;
            r_vec_valid <= 1'b1;
            r_pc        <= r_addr;
            if (r_addr == r_last) r_fin  <= 1'b1;
            else                  r_addr <= r_addr + AW'(1);
          end
        end
        default: begin
          r_op        <= '0;
          r_vec_valid <= 1'b0;
          if (r_state == ST_IDLE && w_launch) begin
            r_addr <= '0;
            r_last <= w_last;
            r_fin  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign line1     = r_op[OP_LINE1];
  assign line2     = r_op[OP_LINE2];
  assign obs       = r_op[OP_OBS];
  assign vec_valid = r_vec_valid;
  assign pc        = 32'(r_pc);
  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_stim_player.sv
// Directed bench for stim_player with an expected-vector queue checked by a
// negedge monitor whenever vec_valid is high.
module tb_stim_player;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [2:0]    wr_data = '0;
  logic          start = 1'b0;
  logic [AW:0]   len = '0;
  logic          stop = 1'b0;
  logic          line1, line2, obs, vec_valid, busy, done;
  logic [31:0]   pc;
  logic [1:0]    dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [34:0] exp_q[$];
  logic [2:0]  model [DEPTH];
  logic [2:0]  orig;

  stim_player #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .len       (len),
    .stop      (stop),
    .line1     (line1),
    .line2     (line2),
    .obs       (obs),
    .vec_valid (vec_valid),
    .pc        (pc),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [34:0] observed, input logic [34:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (reset && vec_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL extra_vector observed=op%0b/pc%0d expected=no_vector", {obs, line2, line1}, pc);
      end else begin
        check("vector", {obs, line2, line1, pc}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [2:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    model[a] = d;
  endtask

  task automatic push_run(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({model[k], 32'(k)});
  endtask

  task automatic start_run(input int l);
    len = (AW+1)'(l); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_vv"},   vec_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_ops"},  {obs, line2, line1}, 3'b000);
  endtask

  // Waits (bounded) for done; exp_n is the tick count from the start tick.
  task automatic wait_done(input string tag, input int exp_n);
    int n = 0;
    while (!done && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, done, 1'b1);
    check({tag, "_done_lat"}, 35'(n), 35'(exp_n));
    check_idle_outputs({tag, "_at_done"});
    tick();
    check({tag, "_done_pulse"}, done, 1'b0);
    check_idle_outputs({tag, "_after"});
    check({tag, "_q_empty"}, 35'(exp_q.size()), 35'd0);
  endtask

  initial begin
    // reset state
    #12;
    check_idle_outputs("reset");
    check("reset_done", done, 1'b0);
    check("reset_pc", pc, 32'd0);
    check("reset_state", dbg_state, 2'd0);
    #4 reset = 1'b1;
    repeat (3) tick();

    // three-vector run
    do_write(0, 3'b001);
    do_write(1, 3'b110);
    do_write(2, 3'b101);
    push_run(3);
    start_run(3);
    check("len3_busy", busy, 1'b1);
    check("len3_fill_vv", vec_valid, 1'b0);
    wait_done("len3", 4);

    // zero-length run
    start_run(0);
    check("len0_busy", busy, 1'b0);
    wait_done("len0", 0);

    // full store, exact and oversized lengths
    for (int k = 0; k < DEPTH; k++) do_write(AW'(k), 3'($urandom_range(0, 7)));
    push_run(16);
    start_run(16);
    wait_done("len16", 17);
    push_run(16);
    start_run(31);
    wait_done("len31", 17);

    // stop on vector 2
    push_run(3);
    start_run(8);
    repeat (3) tick();
    check("stop_pc", pc, 32'd2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle_outputs("stop");
    check("stop_state", dbg_state, 2'd0);
    check("stop_no_done", done, 1'b0);
    tick();
    check("stop_no_done2", done, 1'b0);
    check("stop_q_empty", 35'(exp_q.size()), 35'd0);
    push_run(2);
    start_run(2);
    wait_done("replay", 3);

    // write and start during a run are ignored
    orig = model[1];
    push_run(4);
    start_run(4);
    tick();
    wr_en = 1'b1; wr_addr = 1; wr_data = ~orig;
    start = 1'b1; len = 2;
    tick();
    wr_en = 1'b0; start = 1'b0;
    check("midrun_busy", busy, 1'b1);
    wait_done("midrun", 3);
    push_run(2);
    start_run(2);
    wait_done("store_kept", 3);

    // write coincident with start reaches vector 0
    wr_en = 1'b1; wr_addr = 0; wr_data = ~model[0];
    model[0] = ~model[0];
    push_run(1);
    len = 1; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    wait_done("wr_start", 2);

    // asynchronous reset mid-run
    push_run(8);
    start_run(8);
    repeat (2) tick();
    #2 reset = 1'b0;
    #1;
    check_idle_outputs("arst");
    check("arst_done", done, 1'b0);
    check("arst_pc", pc, 32'd0);
    check("arst_state", dbg_state, 2'd0);
    exp_q.delete();
    #8 reset = 1'b1;
    repeat (3) tick();
    check("arst_idle", dbg_state, 2'd0);
    for (int k = 0; k < 3; k++) do_write(AW'(k), 3'($urandom_range(0, 7)));
    push_run(3);
    start_run(3);
    wait_done("post_arst", 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
